// File: rtl/sim_exit_ctrl_if.sv
// Register-port bundle between a bus master and the simulation exit controller.
// Always-ready request/grant with a single-cycle registered response.
interface sim_exit_ctrl_if;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sim_exit_ctrl.sv
// Simulation exit responder: software exit register, cycle-limit watchdog
// that forces a failing exit, and read-only boot strap capture.
module sim_exit_ctrl #(
   parameter logic [31:0] TIMEOUT_CODE    = 32'hDEAD_0001,
   parameter logic [31:0] WDT_RESET_LIMIT = 32'd0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   sim_exit_ctrl_if.slave        bus,
   input  logic                  boot_select_i,
   input  logic                  execute_from_flash_i,
   output logic                  exit_valid_o,
   output logic [31:0]           exit_value_o
);

   typedef enum logic [2:0] {
      REG_EXIT_VALID = 3'd0,
      REG_EXIT_VALUE = 3'd1,
      REG_WDT_LIMIT  = 3'd2,
      REG_WDT_COUNT  = 3'd3,
      REG_BOOT       = 3'd4
   } reg_sel_e;

   logic        rvalid_q;
   logic [31:0] rdata_q, rdata_d;
   logic        exit_valid_q, exit_valid_d;
   logic [31:0] exit_value_q, exit_value_d;
   logic [31:0] wdt_limit_q, wdt_limit_d;
   logic [31:0] wdt_count_q, wdt_count_d;
   logic [1:0]  boot_q;
   logic        boot_done_q;
   logic        wdt_fire;
   logic        wr_en, rd_en;
   reg_sel_e    reg_sel;
   logic        unused_addr_lsb;

   assign bus.gnt         = bus.req;
   assign bus.rvalid      = rvalid_q;
   assign bus.rdata       = rdata_q;
   assign exit_valid_o    = exit_valid_q;
   assign exit_value_o    = exit_value_q;

   assign wr_en           = bus.req & bus.we;
   assign rd_en           = bus.req & ~bus.we;
   assign reg_sel         = reg_sel_e'(bus.addr[4:2]);
   assign unused_addr_lsb = ^bus.addr[1:0];

   function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      rdata_d      = '0;
      exit_valid_d = exit_valid_q;
      exit_value_d = exit_value_q;
      wdt_limit_d  = wdt_limit_q;
      wdt_count_d  = wdt_count_q;
      wdt_fire     = 1'b0;

      if (rd_en) begin
         case (reg_sel)
            REG_EXIT_VALID: rdata_d = {31'b0, exit_valid_q};
            REG_EXIT_VALUE: rdata_d = exit_value_q;
            REG_WDT_LIMIT:  rdata_d = wdt_limit_q;
            REG_WDT_COUNT:  rdata_d = wdt_count_q;
            REG_BOOT:       rdata_d = {30'b0, boot_q};
            default:        rdata_d = '0;
         endcase
      end

      // After exit the exit registers freeze and the watchdog stops counting.
      if (!exit_valid_q) begin
         wdt_fire = (wdt_limit_q != '0) && (wdt_count_q == wdt_limit_q - 32'd1);
         if ((wdt_limit_q != '0) && (wdt_count_q < wdt_limit_q))
            wdt_count_d = wdt_count_q + 32'd1;
         if (wr_en && reg_sel == REG_EXIT_VALUE)
            exit_value_d = be_merge(exit_value_q, bus.wdata, bus.be);
         if (wr_en && reg_sel == REG_EXIT_VALID && bus.wdata[0]) begin
            exit_valid_d = 1'b1;
            wdt_fire     = 1'b0;
         end
      end

      if (wr_en && reg_sel == REG_WDT_LIMIT) begin
         wdt_limit_d = be_merge(wdt_limit_q, bus.wdata, bus.be);
         wdt_count_d = '0;
         wdt_fire    = 1'b0;
      end

      if (wdt_fire) begin
         exit_valid_d = 1'b1;
         exit_value_d = TIMEOUT_CODE;
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
      if (rst_i) begin
         rvalid_q     <= 1'b0;
         rdata_q      <= '0;
         exit_valid_q <= 1'b0;
         exit_value_q <= '0;
         wdt_limit_q  <= WDT_RESET_LIMIT;
         wdt_count_q  <= '0;
         boot_q       <= '0;
         boot_done_q  <= 1'b0;
      end else begin
         rvalid_q     <= bus.req;
         rdata_q      <= rdata_d;
         exit_valid_q <= exit_valid_d;
         exit_value_q <= exit_value_d;
         wdt_limit_q  <= wdt_limit_d;
         wdt_count_q  <= wdt_count_d;
         if (!boot_done_q) begin
            boot_q      <= {execute_from_flash_i, boot_select_i};
            boot_done_q <= 1'b1;
         end
      end
   end

endmodule
